led_sequencer: RTL and testbench
================================

# led_sequencer

Parametrised LED pattern engine for the board's LED bank: an internal prescaler generates advance ticks, and a small state machine steps a WIDTH-bit pattern in one of four modes (rotate left, rotate right, bounce, binary count). It also supports pause, a manual single-step input and clean re-seeding on mode change. It sits in the top level between the switch/button inputs and the `leds` output bus, replacing the fixed free-running shift-left LED logic.

## Interface
- `WIDTH`, 8, number of LEDs driven; legal range 2..32.
- `DIV`, 1<<25, prescaler modulus in clk cycles per automatic advance; minimum 2.
- `CNT_W`, $clog2(DIV), prescaler counter width (derived; not overridden).

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 = prescaler runs and auto-advances; 0 = paused, prescaler holds.
- `step`  in  1  single-cycle pulse that forces one advance, honoured even when paused.
- `mode`  in  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 binary up-count.
- `leds`  out  WIDTH  current pattern (registered).
- `adv`  out  1  one-cycle pulse, asserted in the same cycle `leds` takes a new advanced value.
- `dir`  out  1  bounce direction: 0 = toward MSB, 1 = toward LSB; 0 in non-bounce modes.

## Operation
- Prescaler: counts 0..DIV-1 while `enable`=1, wraps to 0. `tick` is asserted when count==DIV-1. Holds its value while `enable`=0.
- Advance request: `req = (enable & tick) | step`. A tick and a step in the same cycle produce exactly one advance.
- Seed: if `leds`==0 when an advance occurs, the next value is the mode seed:
  - 00, 10, 11: `1`
  - 01: `1<<(WIDTH-1)`
- Advance from a non-zero value:
  - 00: rotate left by 1; MSB wraps to bit 0.
  - 01: rotate right by 1; bit 0 wraps to MSB.
  - 10: if dir=0, shift left; when the result has the MSB set, dir toggles to 1. If dir=1, shift right; when the result has bit 0 set, dir toggles to 0. No wrap; the sequence reflects at each end without repeating an end value.
  - 11: `leds + 1` modulo 2^WIDTH. All-ones → 0, and the next advance re-seeds to 1.
- Mode change: `mode` is registered every cycle. When it differs from the registered copy, the next cycle clears `leds`→0, dir→0 and prescaler→0, and `adv` is not asserted. Any `req` in that cycle is dropped.
- A non-one-hot value can only reach the shift modes via a mode change, so the mode-change clear guarantees shift/bounce modes always operate on a one-hot value.

## Timing
- Reset values: `leds`=0, `adv`=0, `dir`=0, prescaler=0, registered mode=00. Reset overrides all other inputs in the same cycle. Reset mid-sequence returns to these values on the next edge.
- Latency: `req` in cycle N → new `leds` and `adv`=1 visible at edge N+1. `adv` is high for exactly one cycle per advance.
- With `enable` held at 1 and no `step`, advances occur every DIV cycles. The first occurs DIV cycles after reset release.
- Toggling `enable` 1→0→1 resumes the count from where it paused; no tick is lost or duplicated.
- `step` held high for k cycles produces k advances (level, not edge, sensitive). Debouncing is the caller's responsibility.

## Structure
- Shared package `led_pkg`: mode encodings `MODE_ROL`, `MODE_ROR`, `MODE_BOUNCE`, `MODE_COUNT` and direction constants `DIR_UP`, `DIR_DOWN`.
- One sub-module, `led_tick_gen`: parameter DIV; ports `clk`, `reset`, `enable`, `clear` and a `tick` output. `clear` is driven by mode-change detection.
- The pattern/dir registers and next-state logic stay in `led_sequencer`.

## Test plan
- WIDTH=8, DIV=4, mode=00, enable=1 after reset: `leds` runs 01,02,04,…,80,01, with `adv` every 4th cycle and the first at cycle 4.
- WIDTH=4, DIV=2, mode=10: `leds` runs 1,2,4,8,4,2,1,2; `dir` reads 0,0,0,1,1,1,0,0.
- WIDTH=4, mode=11, enable=0, 17 `step` pulses: `leds` runs 1..F then 0, then 1 on the 17th pulse; `adv` pulses 17 times; the prescaler stays at 0.
- Mode 00 at `leds`=08 (WIDTH=8), switch to 01: the next cycle gives `leds`=0 with `adv`=0, and the first advance gives `leds`=80.
- `step` and `tick` coincident: exactly one advance, one `adv` pulse.
- Assert `reset` mid-bounce with dir=1: the next cycle gives `leds`=0, dir=0, `adv`=0, and the prescaler restarts from 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern engine: mode select values and the
// bounce direction flag.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler for the LED sequencer. It counts 0..DIV-1 while enabled and
// flags the last count. It holds while disabled and can be cleared.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned DIV = 1 << 25
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern engine. It steps a WIDTH-bit pattern on prescaler ticks or
// manual steps, using rotate, bounce or count modes.
//   dir state | meaning
//   DIR_UP    | bounce shifting toward MSB (also the idle value in other modes)
//   DIR_DOWN  | bounce shifting toward LSB
module led_sequencer
  import led_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1 << 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             step,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] leds,
  output logic             adv,
  output logic             dir
);

  localparam logic [WIDTH-1:0] SEED_LSB = WIDTH'(1);
  localparam logic [WIDTH-1:0] SEED_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] leds_q, leds_d;
  logic             dir_q, dir_d;
  logic             adv_q, adv_d;
  mode_e            mode_q;

  logic             tick;
  logic             mode_chg;
  logic             req;
  logic [WIDTH-1:0] shl, shr;

  assign mode_chg = (mode != mode_q);
  assign req      = (enable & tick) | step;
  assign shl      = leds_q << 1;
  assign shr      = leds_q >> 1;

  led_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (mode_chg),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q <= '0;
      dir_q  <= DIR_UP;
      adv_q  <= 1'b0;
      mode_q <= MODE_ROL;
    end else begin
      leds_q <= leds_d;
      dir_q  <= dir_d;
      adv_q  <= adv_d;
      mode_q <= mode_e'(mode);
    end
  end

  // A mode change wins over any pending request so the new mode starts clean.
  always_comb begin
    leds_d = leds_q;
    dir_d  = dir_q;
    adv_d  = 1'b0;
    if (mode_chg) begin
      leds_d = '0;
      dir_d  = DIR_UP;
    end else if (req) begin
      adv_d = 1'b1;
      if (leds_q == '0) begin
        leds_d = (mode_q == MODE_ROR) ? SEED_MSB : SEED_LSB;
      end else begin
        unique case (mode_q)
          MODE_ROL: leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
          MODE_ROR: leds_d = {leds_q[0], leds_q[WIDTH-1:1]};
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              leds_d = shl;
              if (shl[WIDTH-1]) dir_d = DIR_DOWN;
            end else begin
              leds_d = shr;
              if (shr[0]) dir_d = DIR_UP;
            end
          end
          MODE_COUNT: leds_d = leds_q + WIDTH'(1);
          default: leds_d = leds_q;
        endcase
      end
    end
  end

  always_comb begin
    leds = leds_q;
    adv  = adv_q;
    dir  = (mode_q == MODE_BOUNCE) ? dir_q : DIR_UP;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer. A cycle model runs alongside two instances
// (8-bit/DIV=4 and 4-bit/DIV=2) and feeds a per-instance expected queue.
module tb_led_sequencer;

  typedef struct {
    logic [31:0] leds;
    logic        dir;
    logic        adv;
    int          cnt;
    logic [1:0]  mq;
  } mst_t;

  typedef struct {
    logic [31:0] leds;
    logic        adv;
    logic        dir;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst8, en8, st8, rst4, en4, st4;
  logic [1:0] md8, md4;
  logic [7:0] leds8;
  logic [3:0] leds4;
  logic       adv8, dir8, adv4, dir4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mst_t        m8, m4;
  exp_t        q8[$], q4[$];
  logic [31:0] log8[$], log4[$], logd4[$];
  int          advc8[$];

  always #5 clk = ~clk;

  led_sequencer #(.WIDTH(8), .DIV(4)) u_dut8 (
    .clk(clk), .reset(rst8), .enable(en8), .step(st8), .mode(md8),
    .leds(leds8), .adv(adv8), .dir(dir8)
  );

  led_sequencer #(.WIDTH(4), .DIV(2)) u_dut4 (
    .clk(clk), .reset(rst4), .enable(en4), .step(st4), .mode(md4),
    .leds(leds4), .adv(adv4), .dir(dir4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic mst_t mnext(mst_t s, int w, int div, logic rst, logic en,
                                 logic st, logic [1:0] md);
    mst_t n;
    logic [31:0] mask;
    logic tk;
    n = s;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    n.adv = 1'b0;
    n.mq  = md;
    if (rst) begin
      n.leds = 0; n.dir = 0; n.cnt = 0; n.mq = 2'b00;
      return n;
    end
    if (md != s.mq) begin
      n.leds = 0; n.dir = 0; n.cnt = 0;
      return n;
    end
    tk = (s.cnt == div - 1);
    if (en) n.cnt = tk ? 0 : s.cnt + 1;
    if ((en && tk) || st) begin
      n.adv = 1'b1;
      if (s.leds == 0) begin
        n.leds = (md == 2'b01) ? (32'd1 << (w - 1)) : 32'd1;
      end else begin
        case (md)
          2'b00: n.leds = ((s.leds << 1) | (s.leds >> (w - 1))) & mask;
          2'b01: n.leds = ((s.leds >> 1) | (s.leds << (w - 1))) & mask;
          2'b10: begin
            if (!s.dir) begin
              n.leds = (s.leds << 1) & mask;
              if (n.leds[w-1]) n.dir = 1'b1;
            end else begin
              n.leds = s.leds >> 1;
              if (n.leds[0]) n.dir = 1'b0;
            end
          end
          default: n.leds = (s.leds + 32'd1) & mask;
        endcase
      end
    end
    return n;
  endfunction

  task automatic tick_cycle();
    exp_t e8, e4;
    m8 = mnext(m8, 8, 4, rst8, en8, st8, md8);
    q8.push_back('{m8.leds, m8.adv, m8.dir});
    m4 = mnext(m4, 4, 2, rst4, en4, st4, md4);
    q4.push_back('{m4.leds, m4.adv, m4.dir});
    @(posedge clk);
    #1;
    cyc++;
    e8 = q8.pop_front();
    chk("d8_leds", 32'(leds8), e8.leds);
    chk("d8_adv",  32'(adv8),  32'(e8.adv));
    chk("d8_dir",  32'(dir8),  32'(e8.dir));
    e4 = q4.pop_front();
    chk("d4_leds", 32'(leds4), e4.leds);
    chk("d4_adv",  32'(adv4),  32'(e4.adv));
    chk("d4_dir",  32'(dir4),  32'(e4.dir));
    if (adv8) begin log8.push_back(32'(leds8)); advc8.push_back(cyc); end
    if (adv4) begin log4.push_back(32'(leds4)); logd4.push_back(32'(dir4)); end
  endtask

  initial begin
    logic [31:0] rol_tab[10]   = '{1, 2, 4, 8, 16, 32, 64, 128, 1, 2};
    logic [31:0] bnc_tab[8]    = '{1, 2, 4, 8, 4, 2, 1, 2};
    logic [31:0] bnc_dir[8]    = '{0, 0, 0, 1, 1, 1, 0, 0};
    logic [31:0] stp_tab[3]    = '{32'h10, 32'h08, 32'h04};
    int start, n, k;

    m8 = '{default: 0};
    m4 = '{default: 0};
    rst8 = 1; en8 = 0; st8 = 0; md8 = 2'b00;
    rst4 = 1; en4 = 0; st4 = 0; md4 = 2'b00;
    repeat (2) tick_cycle();
    chk("rst_leds8", 32'(leds8), 0);
    chk("rst_adv8",  32'(adv8),  0);

    // Rotate left, 8 bits, DIV=4.
    rst8 = 0; rst4 = 0; en8 = 1;
    log8.delete(); advc8.delete();
    start = cyc;
    repeat (40) tick_cycle();
    chk("rol_count", log8.size(), 10);
    for (int i = 0; i < 10 && i < log8.size(); i++) begin
      chk("rol_seq", log8[i], rol_tab[i]);
      chk("rol_time", advc8[i] - start, 4 * (i + 1));
    end

    // Mode switch at leds=08, with a step that must be dropped.
    k = 0;
    while (leds8 != 8'h08 && k < 20) begin tick_cycle(); k++; end
    chk("wait_08", 32'(leds8), 32'h08);
    md8 = 2'b01; en8 = 0; st8 = 1;
    tick_cycle();
    chk("mchg_leds", 32'(leds8), 0);
    chk("mchg_adv",  32'(adv8),  0);
    st8 = 0;
    tick_cycle();
    st8 = 1;
    tick_cycle();
    st8 = 0;
    chk("ror_seed", 32'(leds8), 32'h80);
    chk("ror_seed_adv", 32'(adv8), 1);

    // Step coincident with tick: one advance only.
    en8 = 1;
    repeat (3) tick_cycle();
    st8 = 1;
    tick_cycle();
    st8 = 0;
    chk("coinc_adv",  32'(adv8),  1);
    chk("coinc_leds", 32'(leds8), 32'h40);
    n = 0;
    repeat (3) begin tick_cycle(); n += int'(adv8); end
    chk("coinc_quiet", n, 0);
    tick_cycle();
    chk("coinc_next", 32'(leds8), 32'h20);

    // Step held as a level while paused.
    en8 = 0; st8 = 1;
    log8.delete();
    repeat (3) tick_cycle();
    st8 = 0;
    tick_cycle();
    chk("level_count", log8.size(), 3);
    for (int i = 0; i < 3 && i < log8.size(); i++) chk("level_seq", log8[i], stp_tab[i]);

    // Bounce, 4 bits, DIV=2.
    md4 = 2'b10;
    tick_cycle();
    en4 = 1;
    log4.delete(); logd4.delete();
    repeat (16) tick_cycle();
    chk("bnc_count", log4.size(), 8);
    for (int i = 0; i < 8 && i < log4.size(); i++) begin
      chk("bnc_seq", log4[i], bnc_tab[i]);
      chk("bnc_dir", logd4[i], bnc_dir[i]);
    end

    // Reset while heading down.
    k = 0;
    while (dir4 != 1'b1 && k < 20) begin tick_cycle(); k++; end
    chk("wait_dir1", 32'(dir4), 1);
    rst4 = 1;
    tick_cycle();
    chk("mrst_leds", 32'(leds4), 0);
    chk("mrst_dir",  32'(dir4),  0);
    chk("mrst_adv",  32'(adv4),  0);
    rst4 = 0;
    k = 0;
    do begin tick_cycle(); k++; end while (!adv4 && k < 10);
    chk("mrst_first_adv", k, 3);
    chk("mrst_first_leds", 32'(leds4), 1);

    // Binary count by steps while paused.
    en4 = 0; md4 = 2'b11;
    tick_cycle();
    log4.delete();
    for (int i = 0; i < 17; i++) begin
      st4 = 1; tick_cycle();
      st4 = 0; tick_cycle();
    end
    chk("cnt_count", log4.size(), 17);
    for (int i = 0; i < 17 && i < log4.size(); i++) chk("cnt_seq", log4[i], (i + 1) & 15);
    en4 = 1;
    tick_cycle();
    chk("cnt_pre_hold", 32'(adv4), 0);
    tick_cycle();
    chk("cnt_pre_tick", 32'(adv4), 1);
    chk("cnt_pre_leds", 32'(leds4), 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
